// File: rtl/laser_frame_rx.sv
// laser_frame_rx: recovers one packet frame (start bit, PKT_LENGTH data bits
// MSB first, stop bit) from the raw photodiode line. Start glitches are
// rejected, every bit is a 3-sample majority vote around mid-bit, and a low
// stop bit is reported as a framing error instead of a packet.
module laser_frame_rx #(
   parameter int CLK_PER_BIT = 13540,
   parameter int PKT_LENGTH  = 288
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx,
   output logic [PKT_LENGTH-1:0] data,
   output logic                  new_data,
   output logic                  frame_err,
   output logic                  busy,
   output logic [15:0]           pkt_count
);

   localparam int M     = CLK_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLK_PER_BIT);
   localparam int IDX_W = (PKT_LENGTH > 1) ? $clog2(PKT_LENGTH) : 1;

   // Sample points around mid-bit; the decision is taken on the third one.
   localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(M - 1);
   localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(M);
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(M + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LENGTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t                state;
   logic                  rx_meta;
   logic                  rx_s;
   logic                  rx_d;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      bit_idx;
   logic                  smp_a;
   logic                  smp_b;
   logic                  vote;
   logic [PKT_LENGTH-1:0] shreg;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // The third sample is taken live on the decision edge.
   assign vote = maj3(smp_a, smp_b, rx_s);
   assign busy = (state != IDLE);

   // Two-flop synchronizer plus one history flop; all idle-high out of reset
   // so releasing reset can never look like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   // Capture the first two mid-bit samples of the current bit period.
   always_ff @(posedge clk) begin
      if (cnt == CNT_S0) smp_a <= rx_s;
      if (cnt == CNT_S1) smp_b <= rx_s;
   end

   // Shift each voted data bit in at the LSB so the first bit ends at the MSB.
   always_ff @(posedge clk) begin
      if (state == DATA && cnt == CNT_DEC) begin
         shreg <= {shreg[PKT_LENGTH-2:0], vote};
      end
   end

   // Frame state machine with registered packet, pulse and counter outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         data      <= '0;
         new_data  <= 1'b0;
         frame_err <= 1'b0;
         pkt_count <= '0;
      end else begin
         new_data  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_d && !rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CNT_DEC && vote) begin
                  // Line went back high before mid-start: treat as a glitch.
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state   <= DATA;
                  cnt     <= '0;
                  bit_idx <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_ONE;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STOP: begin
               // Leave at mid-stop so a back-to-back start edge is not missed.
               if (cnt == CNT_DEC) begin
                  if (vote) begin
                     data      <= shreg;
                     new_data  <= 1'b1;
                     pkt_count <= pkt_count + 16'd1;
                     state     <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            WAIT_IDLE: begin
               // Hold off edge detection until the line has recovered high.
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_laser_frame_rx.sv
// Bench for laser_frame_rx with CLK_PER_BIT=16, PKT_LENGTH=8.
// Frames are driven bit by bit on rx; expected pulse timing, data and
// packet count come from the frame arithmetic, not from the design.
module tb_laser_frame_rx;

   localparam int C = 16;
   localparam int P = 8;
   localparam int M = C / 2;
   localparam int PULSE_OFF = (P + 1) * C + M + 3;

   logic         clk;
   logic         rst_n;
   logic         rx;
   logic [P-1:0] data;
   logic         new_data;
   logic         frame_err;
   logic         busy;
   logic [15:0]  pkt_count;

   laser_frame_rx #(.CLK_PER_BIT(C), .PKT_LENGTH(P)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .new_data  (new_data),
      .frame_err (frame_err),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   typedef struct {
      int           cyc;
      logic         kind;
      logic [P-1:0] d;
      logic [15:0]  cnt;
   } ev_t;

   ev_t         evq[$];
   int          cyc = 0;
   int          busy_rise = -1;
   int          busy_fall = -1;
   logic        busy_q = 1'b0;
   logic        both_seen = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt;
   logic [P-1:0] exp_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record output pulses and busy edges, stamped with the cycle number.
   always @(negedge clk) begin
      if (rst_n) begin
         if (new_data)  evq.push_back(ev_t'{cyc, 1'b0, data, pkt_count});
         if (frame_err) evq.push_back(ev_t'{cyc, 1'b1, data, pkt_count});
         if (new_data && frame_err) both_seen <= 1'b1;
      end
      if (busy && !busy_q) busy_rise <= cyc;
      if (!busy && busy_q) busy_fall <= cyc;
      busy_q <= busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rx = 1'b1;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".data"},      32'(data), 32'(0));
      chk({tag, ".new_data"},  32'(new_data), 32'(0));
      chk({tag, ".frame_err"}, 32'(frame_err), 32'(0));
      chk({tag, ".busy"},      32'(busy), 32'(0));
      chk({tag, ".pkt_count"}, 32'(pkt_count), 32'(0));
   endtask

   // Drive one frame: start, P data bits MSB first, stop, then optional
   // extra low cycles. spike inverts the line for one clock at mid-bit of
   // every data bit. abort_at >= 0 asserts reset at that frame offset.
   task automatic send_frame(input logic [P-1:0] b, input logic good_stop,
                             input logic spike, input int extra_low,
                             input int abort_at, output int e0);
      e0 = 0;
      for (int t = 0; t < (P + 2) * C; t++) begin
         int   k;
         int   j;
         logic v;
         k = t / C;
         j = t % C;
         if (k == 0)      v = 1'b0;
         else if (k <= P) v = b[P-k];
         else             v = good_stop;
         if (spike && k >= 1 && k <= P && j == M + 1) v = ~v;
         @(posedge clk); #1;
         if (t == 0) e0 = cyc;
         rx = v;
         if (t == abort_at) begin
            #2 rst_n = 1'b0;
            #1 chk_reset_outputs("midreset");
            rx = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            return;
         end
      end
      if (extra_low > 0) begin
         repeat (extra_low) begin
            @(posedge clk); #1;
            rx = 1'b0;
         end
         @(posedge clk); #1;
         rx = 1'b1;
      end
   endtask

   task automatic expect_frame(input string tag, input int e0, input logic good,
                               input logic [P-1:0] b, input int fall_off);
      if (good) begin
         exp_cnt  = exp_cnt + 16'd1;
         exp_data = b;
      end
      chk({tag, ".events"}, 32'(evq.size()), 32'(1));
      if (evq.size() > 0) begin
         chk({tag, ".kind"},  32'(evq[0].kind), 32'(!good));
         chk({tag, ".cycle"}, 32'(evq[0].cyc), 32'(e0 + 2 + PULSE_OFF));
         chk({tag, ".data"},  32'(evq[0].d), 32'(exp_data));
         chk({tag, ".count"}, 32'(evq[0].cnt), 32'(exp_cnt));
      end
      chk({tag, ".busy_rise"}, 32'(busy_rise), 32'(e0 + 3));
      chk({tag, ".busy_fall"}, 32'(busy_fall), 32'(e0 + 2 + fall_off));
      chk({tag, ".hold"},      32'(data), 32'(exp_data));
      chk({tag, ".both"},      32'(both_seen), 32'(0));
      evq.delete();
   endtask

   initial begin
      int          e0;
      logic [P-1:0] b;
      logic        sp;

      rx       = 1'b1;
      rst_n    = 1'b0;
      exp_cnt  = 16'd0;
      exp_data = '0;
      repeat (3) @(posedge clk);
      #1 chk_reset_outputs("reset");
      rst_n = 1'b1;
      idle(5);

      // Good frame 0xA5.
      send_frame(8'hA5, 1'b1, 1'b0, 0, -1, e0);
      idle(5);
      expect_frame("good_a5", e0, 1'b1, 8'hA5, PULSE_OFF);

      // Three-clock start glitch.
      @(posedge clk); #1;
      e0 = cyc;
      rx = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rx = 1'b1;
      idle(30);
      chk("glitch.events", 32'(evq.size()), 32'(0));
      chk("glitch.busy_rise", 32'(busy_rise), 32'(e0 + 3));
      chk("glitch.busy_fall", 32'(busy_fall), 32'(e0 + 2 + M + 3));
      chk("glitch.data", 32'(data), 32'(exp_data));
      chk("glitch.count", 32'(pkt_count), 32'(exp_cnt));
      evq.delete();

      // Majority vote rejects a mid-bit spike in every data bit.
      send_frame(8'h3C, 1'b1, 1'b1, 0, -1, e0);
      idle(5);
      expect_frame("vote_3c", e0, 1'b1, 8'h3C, PULSE_OFF);

      // Framing error with the line stuck low after the stop bit.
      send_frame(8'hFF, 1'b0, 1'b0, 40, -1, e0);
      idle(40);
      expect_frame("ferr", e0, 1'b0, 8'hFF, (P + 2) * C + 40 + 1);
      idle(30);
      chk("ferr.no_restart", 32'(evq.size()), 32'(0));
      chk("ferr.busy_low", 32'(busy), 32'(0));
      evq.delete();

      // Randomised good frames with random gaps and spikes.
      for (int i = 0; i < 6; i++) begin
         b  = P'($urandom_range(0, 255));
         sp = 1'($urandom_range(0, 1));
         idle($urandom_range(1, 20));
         send_frame(b, 1'b1, sp, 0, -1, e0);
         idle(3);
         expect_frame("random", e0, 1'b1, b, PULSE_OFF);
      end

      // Counter wrap with two back-to-back frames.
      idle(5);
      force dut.pkt_count = 16'hFFFF;
      @(posedge clk); #1;
      release dut.pkt_count;
      exp_cnt = 16'hFFFF;
      idle(3);
      chk("wrap.preload", 32'(pkt_count), 32'(16'hFFFF));
      send_frame(8'h01, 1'b1, 1'b0, 0, -1, e0);
      expect_frame("b2b_01", e0, 1'b1, 8'h01, PULSE_OFF);
      send_frame(8'h80, 1'b1, 1'b0, 0, -1, e0);
      idle(3);
      expect_frame("b2b_80", e0, 1'b1, 8'h80, PULSE_OFF);

      // Reset asserted during data bit 4, then a clean frame.
      idle(5);
      send_frame(8'h99, 1'b1, 1'b0, 0, 5 * C + 4, e0);
      exp_cnt  = 16'd0;
      exp_data = '0;
      evq.delete();
      idle(40);
      chk("midreset.no_pulse", 32'(evq.size()), 32'(0));
      chk("midreset.busy", 32'(busy), 32'(0));
      chk("midreset.count", 32'(pkt_count), 32'(0));
      send_frame(8'h5A, 1'b1, 1'b0, 0, -1, e0);
      idle(5);
      expect_frame("after_reset_5a", e0, 1'b1, 8'h5A, PULSE_OFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/laser_frame_rx.md
# laser_frame_rx

Photodiode-side frame receiver for the laser link. It sits directly upstream of `receivepacket`, which decodes the TCP fields. It recovers one packet frame from the raw photodiode line, with bit timing matched to the laser transmitter. The frame format is start bit, `PKT_LENGTH` data bits MSB first, then a stop bit. The block rejects start glitches, majority-votes each bit, flags framing errors and presents the packet with a one-cycle `new_data` strobe.

## Interface
Parameters:
- `CLK_PER_BIT`, default 13540: clocks per bit; must be ≥ 4.
- `PKT_LENGTH`, default 288: data bits per frame (32*9).

Ports:
- `clk`, input, 1: system clock (65 MHz in the labkit).
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `rx`, input, 1: raw photodiode line from JA[1]; idle high; asynchronous to `clk`.
- `data`, output, `PKT_LENGTH`: last good frame; first received bit is in `data[PKT_LENGTH-1]`.
- `new_data`, output, 1: one-cycle pulse; `data` is valid and updated in the same cycle.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, output, 1: high whenever the state is not IDLE.
- `pkt_count`, output, 16: count of good frames; wraps at 16'hFFFF to 0.

## Operation
- **Input conditioning:**
  - `rx` passes through a 2-flop synchronizer to give `rx_s`, plus one more flop giving `rx_d`.
  - All three flops reset to 1, so reset release never creates a false start edge.
- **Counters:**
  - `cnt` counts 0..`CLK_PER_BIT`-1 within each bit period.
  - `bit_idx` counts 0..`PKT_LENGTH`-1.
  - M = `CLK_PER_BIT`/2, using integer division.
- **Bit decision:** `rx_s` is sampled at `cnt` = M-1, M and M+1. The bit value is the majority of the 3 samples, decided on the edge where `cnt` = M+1.
- **States:**
  - **IDLE:** when `rx_d`=1 and `rx_s`=0 (falling edge), go to START with `cnt`←0. Otherwise stay.
  - **START:** at the M+1 decision:
    - majority 1: glitch; go to IDLE with no pulse.
    - majority 0: continue. At `cnt`=`CLK_PER_BIT`-1, go to DATA with `cnt`←0 and `bit_idx`←0.
  - **DATA:** at the M+1 decision, shift the majority bit into the LSB of the shift register (shift left). At `cnt`=`CLK_PER_BIT`-1:
    - `bit_idx`=`PKT_LENGTH`-1: go to STOP with `cnt`←0.
    - otherwise: `bit_idx`++ and `cnt`←0.
  - **STOP:** at the M+1 decision:
    - majority 1: `data`←shift register, `new_data`←1, `pkt_count`++, go to IDLE.
    - majority 0: `frame_err`←1, `data` unchanged, go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rx_s`=1, then go to IDLE. This prevents a false start inside a stuck-low line.
- **Return to IDLE:** STOP returns to IDLE at mid-stop-bit, so a back-to-back frame whose start edge follows immediately is caught.
- **`rx_d` tracking:** `rx_d` follows `rx_s` in every state. Edge detection in IDLE therefore uses true history.

## Timing
- **Reset values:** `data`=0, `new_data`=0, `frame_err`=0, `busy`=0, `pkt_count`=0, state=IDLE. Reset applies immediately (asynchronous).
- **Reset mid-frame:** the partial frame is discarded and no pulse is produced.
- **Latency:** let cycle 0 be the first cycle with `rx_s`=0.
  - `busy` rises in cycle 1.
  - `new_data` (or `frame_err`) is high in exactly cycle (`PKT_LENGTH`+1)·`CLK_PER_BIT` + M + 3.
  - `busy` falls in that same cycle.
  - `rx_s` lags the `rx` pin by 2 clocks.
- **Pulses:** `new_data` and `frame_err` are each exactly one cycle wide, registered, and never asserted together.
- **`data` stability:** `data` holds between good frames. It is never partially updated.
- **`pkt_count`:** increments in the same cycle `new_data` is high; 16'hFFFF+1 → 0.
- **Backpressure:** none. The consumer must take `data` before the next `new_data`, which is at least (`PKT_LENGTH`+2)·`CLK_PER_BIT` later.

## Test plan
All scenarios use `CLK_PER_BIT`=16, `PKT_LENGTH`=8, M=8.
- **Good frame:** send 0xA5 with a good stop bit → `new_data` is a 1-cycle pulse 155 cycles after `rx_s` first goes low. `data`=8'hA5, `pkt_count`=1, no `frame_err`, and `busy` is high for cycles 1..154 and falls at 155.
- **Start glitch:** pulse `rx` low for 3 clocks → state returns to IDLE and `busy` drops at `cnt`=M+1. No `new_data`, no `frame_err`, `data` unchanged.
- **Majority vote:** send 0x3C with a 1-clock inverted spike at `cnt`=M in every bit → `data`=8'h3C and `new_data` pulses.
- **Framing error:** send 0xFF with the stop bit held low, then `rx` held low 40 more clocks, then high → `frame_err` pulses once and `data` keeps its previous value. State stays in WAIT_IDLE until `rx_s` is high, and no spurious start follows.
- **Back-to-back and wrap:** force `pkt_count` to 16'hFFFF (preload via 65535 frames, or `force`), then send 0x01 followed with no gap by 0x80 → two `new_data` pulses with `data`=8'h01 then 8'h80. `pkt_count` reads 0, then 1.
- **Mid-frame reset:** pull `rst_n` low during DATA bit 4 → all outputs read reset values immediately. After release with `rx` idle high, no pulse occurs, and a following good frame of 0x5A is received correctly.
